uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings, default
// frame constants and a width helper for counters.
package uart_pkg;

  // Receiver/transmitter line states; all four encodings are used
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int CLOCKS_PER_PULSE_DEF = 16;
  localparam int DATA_WIDTH_DEF       = 8;

  // Counter width able to index n positions, never narrower than one bit
  function automatic int cnt_width(input int n);
    if (n > 2) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit with a selectable
// reset value, so an idle-high line stays high through reset release.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // First stage may go metastable; second stage presents a settled value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start(0), DATA_WIDTH bits LSB first, stop(1).
// Start is found on a falling edge of the synchronized line, confirmed at
// mid start bit, then every bit is sampled one full bit period later.
// The stop bit is sampled at its middle so a following start edge can be
// caught without a gap between frames.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = CLOCKS_PER_PULSE_DEF,
  parameter int DATA_WIDTH       = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  framing_err,
  output logic                  rx_busy
);

  localparam int CNT_W = cnt_width(CLOCKS_PER_PULSE);
  localparam int IDX_W = cnt_width(DATA_WIDTH);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  logic rx_s;   // synchronized line, the only value decisions look at
  logic rx_d;   // rx_s delayed one cycle, for falling-edge detection

  uart_state_e            state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   framing_err_q, framing_err_d;
  logic                   rx_busy_q;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rx_s)
  );

  // Delayed copy of the synchronized line; resets high like the line idles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_d <= 1'b1;
    end else begin
      rx_d <= rx_s;
    end
  end

  // Next-state, bit timing, shift and output-pulse decisions
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    framing_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        idx_d = {IDX_W{1'b0}};
        // Only a true high-to-low edge starts a frame, not a held-low line
        if (rx_d && !rx_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          // Line back high at mid start bit means it was a glitch
          if (!rx_s) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d          = {CNT_W{1'b0}};
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
            idx_d   = {IDX_W{1'b0}};
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = IDLE;
          if (rx_s) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
          end else begin
            framing_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      idx_q         <= {IDX_W{1'b0}};
      shift_q       <= {DATA_WIDTH{1'b0}};
      data_out_q    <= {DATA_WIDTH{1'b0}};
      data_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
      rx_busy_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      framing_err_q <= framing_err_d;
      rx_busy_q     <= (state_d != IDLE);
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign framing_err = framing_err_q;
  assign rx_busy     = rx_busy_q;

endmodule
